// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory with power-on NOP fill, stall hold and out-of-range fault reporting.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag corrupted reads.
module instr_mem_ctrl #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack,
  output logic              init_done,
  output logic              parity_err
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              fault_q;
  logic              perr_q;
  logic              ack_q;
  logic              done_q;

  logic [WORD_W-1:0] mem [DEPTH];

  logic              fetch_accept;
  logic              fetch_in_range;
  logic              prog_in_range;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;
  logic              rd_par_ok;
  logic [DATA_W-1:0] fetch_word;

  assign fetch_ready    = (state_q == StReady) && !stall;
  assign fetch_accept   = fetch_ready && fetch_req;
  // Widen by one bit so the compare still works when DEPTH == 2**ADDR_W.
  assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_X;
  assign prog_in_range  = {1'b0, prog_addr} < DEPTH_X;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = NOP_WORD;
    if (state_q == StInit) begin
      wr_en  = 1'b1;
      wr_idx = cnt_q[IDX_W-1:0];
    end else if (prog_we && prog_in_range) begin
      wr_en   = 1'b1;
      wr_idx  = prog_addr[IDX_W-1:0];
      wr_data = prog_data;
    end
  end

  assign rd_word = mem[fetch_addr[IDX_W-1:0]];

`ifdef IMEM_PARITY_EN
  assign wr_word   = {^wr_data, wr_data};
  assign rd_data   = rd_word[DATA_W-1:0];
  assign rd_par_ok = ~^rd_word;
`else
  assign wr_word   = wr_data;
  assign rd_data   = rd_word;
  assign rd_par_ok = 1'b1;
`endif

  always_comb begin
    fetch_word = rd_data;
    if (!fetch_in_range || !rd_par_ok) begin
      fetch_word = NOP_WORD;
    end
  end

  // Array has no reset; its contents are defined by the INIT fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      perr_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          ack_q <= 1'b0;
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == LAST) begin
            state_q <= StReady;
            done_q  <= 1'b1;
          end
        end
        StReady: begin
          ack_q <= prog_we && prog_in_range;
        end
        default: state_q <= StInit;
      endcase

      // Stall freezes the whole result register; otherwise it tracks the accepted fetch.
      if (!stall) begin
        if (fetch_accept) begin
          instr_q <= fetch_word;
          valid_q <= 1'b1;
          fault_q <= !fetch_in_range;
          perr_q  <= fetch_in_range && !rd_par_ok;
        end else begin
          valid_q <= 1'b0;
          fault_q <= 1'b0;
          perr_q  <= 1'b0;
        end
      end
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign addr_fault  = fault_q;
  assign prog_ack    = ack_q;
  assign init_done   = done_q;
  assign parity_err  = perr_q;

endmodule
